// File: rtl/eth_rx_dma.sv
// rtl/eth_rx_dma.sv - AXI4-lite read master that drains Ethernet RX frames into word-wide memory.
module eth_rx_dma #(
  parameter logic [7:0] RX_ADDR     = 8'h00,
  parameter logic [7:0] STATUS_ADDR = 8'h04,
  parameter int         RXEMPTY_BIT = 1,
  parameter int         RXRESET_BIT = 2,
  parameter int         RD_GAP      = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] max_len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] rx_len_o,
  output logic        m_arvalid_o,
  input  logic        m_arready_i,
  output logic [31:0] m_araddr_o,
  input  logic        m_rvalid_i,
  output logic        m_rready_o,
  input  logic [31:0] m_rdata_i,
  input  logic [1:0]  m_rresp_i,
  output logic        m_awvalid_o,
  output logic        m_wvalid_o,
  output logic [31:0] m_awaddr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wstrb_o,
  output logic        m_bready_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_accept_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_LEN_HI, S_LEN_LO, S_DATA, S_MEM_WR, S_DONE
  } state_e;

  // Reload value so that exactly RD_GAP idle cycles separate an RX R handshake from the next AR.
  localparam logic [7:0] GAP_RELOAD = (RD_GAP > 0) ? 8'(RD_GAP - 1) : 8'd0;

  state_e      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        ovf_q, ovf_d, rxrst_q, rxrst_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d, mem_wr_q, mem_wr_d;
  logic [7:0]  araddr_q, araddr_d, gap_q, gap_d;
  logic [15:0] len_q, len_d, max_q, max_d, cnt_q, cnt_d;
  logic [13:0] widx_q, widx_d;
  logic [31:0] base_q, base_d, word_q, word_d;
  logic [3:0]  strb_q, strb_d;

  logic        rx_fire, can_issue, last_byte;
  logic [15:0] new_len;
  logic        unused_ok;

  assign unused_ok = ^{m_rresp_i, m_rdata_i, base_addr_i[1:0]};

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ovf_d     = ovf_q;
    rxrst_d   = rxrst_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    mem_wr_d  = mem_wr_q;
    araddr_d  = araddr_q;
    gap_d     = (gap_q != 8'd0) ? gap_q - 8'd1 : gap_q;
    len_d     = len_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    base_d    = base_q;
    word_d    = word_q;
    strb_d    = strb_q;
    new_len   = {len_q[15:8], m_rdata_i[7:0]};
    last_byte = (cnt_q == len_q - 16'd1);
    rx_fire   = rready_q && m_rvalid_i;
    can_issue = !arvalid_q && !rready_q && (gap_q == 8'd0);

    if (arvalid_q && m_arready_i) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end
    if (rx_fire) rready_d = 1'b0;

    if ((state_q == S_POLL || state_q == S_LEN_HI || state_q == S_LEN_LO ||
         state_q == S_DATA) && can_issue) begin
      arvalid_d = 1'b1;
      araddr_d  = (state_q == S_POLL) ? STATUS_ADDR : RX_ADDR;
    end
    if (rx_fire && state_q != S_POLL) gap_d = GAP_RELOAD;

    case (state_q)
      S_IDLE: if (start_i) begin
        busy_d  = 1'b1;
        base_d  = {base_addr_i[31:2], 2'b00};
        max_d   = max_len_i;
        len_d   = 16'd0;
        cnt_d   = 16'd0;
        widx_d  = 14'd0;
        word_d  = 32'd0;
        strb_d  = 4'd0;
        ovf_d   = 1'b0;
        rxrst_d = 1'b0;
        gap_d   = 8'd0;
        state_d = S_POLL;
      end
      S_POLL: if (rx_fire) begin
        if (m_rdata_i[RXRESET_BIT]) begin
          rxrst_d = 1'b1;
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (!m_rdata_i[RXEMPTY_BIT]) begin
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: if (rx_fire) begin
        len_d[15:8] = m_rdata_i[7:0];
        state_d     = S_LEN_LO;
      end
      S_LEN_LO: if (rx_fire) begin
        len_d = new_len;
        if (new_len == 16'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          ovf_d   = (new_len > max_q);
          state_d = S_DATA;
        end
      end
      S_DATA: if (rx_fire) begin
        cnt_d = cnt_q + 16'd1;
        if (ovf_q) begin
          if (last_byte) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          word_d[{cnt_q[1:0], 3'b000} +: 8] = m_rdata_i[7:0];
          strb_d[cnt_q[1:0]]                = 1'b1;
          if (cnt_q[1:0] == 2'd3 || last_byte) begin
            mem_wr_d = 1'b1;
            state_d  = S_MEM_WR;
          end
        end
      end
      S_MEM_WR: if (mem_accept_i) begin
        mem_wr_d = 1'b0;
        word_d   = 32'd0;
        strb_d   = 4'd0;
        widx_d   = widx_q + 14'd1;
        if (cnt_q == len_q) begin
          done_d  = 1'b1;
          err_d   = ovf_q | rxrst_q;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rxrst_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      araddr_q  <= 8'd0;
      gap_q     <= 8'd0;
      len_q     <= 16'd0;
      max_q     <= 16'd0;
      cnt_q     <= 16'd0;
      widx_q    <= 14'd0;
      base_q    <= 32'd0;
      word_q    <= 32'd0;
      strb_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      rxrst_q   <= rxrst_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      mem_wr_q  <= mem_wr_d;
      araddr_q  <= araddr_d;
      gap_q     <= gap_d;
      len_q     <= len_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      base_q    <= base_d;
      word_q    <= word_d;
      strb_q    <= strb_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rx_len_o    = len_q;
  assign m_arvalid_o = arvalid_q;
  assign m_araddr_o  = {24'd0, araddr_q};
  assign m_rready_o  = rready_q;
  assign m_awvalid_o = 1'b0;
  assign m_wvalid_o  = 1'b0;
  assign m_awaddr_o  = 32'd0;
  assign m_wdata_o   = 32'd0;
  assign m_wstrb_o   = 4'd0;
  assign m_bready_o  = 1'b1;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_wr_q ? base_q + {16'd0, widx_q, 2'b00} : 32'd0;
  assign mem_wdata_o = mem_wr_q ? word_q : 32'd0;
  assign mem_wstrb_o = mem_wr_q ? strb_q : 4'd0;

endmodule

// File: tb/tb_eth_rx_dma.sv
// tb/tb_eth_rx_dma.sv - randomized scoreboard bench for eth_rx_dma with an AXI-lite slave model.
module tb_eth_rx_dma;
  localparam int         RD_GAP = 2;
  localparam logic [7:0] RX_A   = 8'h00;
  localparam logic [7:0] ST_A   = 8'h04;

  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] max_len_i = '0;
  logic        busy_o, done_o, err_o;
  logic [15:0] rx_len_o;
  logic        m_arvalid_o, m_arready_i = 1'b0;
  logic [31:0] m_araddr_o;
  logic        m_rvalid_i = 1'b0, m_rready_o;
  logic [31:0] m_rdata_i = '0;
  logic [1:0]  m_rresp_i = '0;
  logic        m_awvalid_o, m_wvalid_o, m_bready_o;
  logic [31:0] m_awaddr_o, m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic        mem_wr_o, mem_accept_i = 1'b0;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;

  always #5 clk = ~clk;

  eth_rx_dma dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .max_len_i(max_len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rx_len_o(rx_len_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_araddr_o(m_araddr_o), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_awvalid_o(m_awvalid_o),
    .m_wvalid_o(m_wvalid_o), .m_awaddr_o(m_awaddr_o), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o), .m_bready_o(m_bready_o), .mem_wr_o(mem_wr_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_accept_i(mem_accept_i)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  typedef struct { logic err; logic [15:0] len; } done_t;

  logic [31:0] status_q[$];
  logic [7:0]  rx_q[$];
  wr_t         exp_wr[$];
  done_t       exp_done[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int st_reads = 0, rx_reads = 0, done_cnt = 0, proto_err = 0;
  int stall = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Slave and memory drivers: act just after each edge, using what was on the bus before it.
  logic        p_arv = 1'b0, p_arr = 1'b0, p_rv = 1'b0, p_rr = 1'b0;
  logic [7:0]  p_addr = '0;
  bit          pend = 0;
  int          dly = 0;
  logic [31:0] pdata = '0, tmp = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_ni) begin
      m_arready_i  = 1'b0;
      m_rvalid_i   = 1'b0;
      mem_accept_i = 1'b0;
      pend         = 0;
    end else begin
      if (p_rv && p_rr) m_rvalid_i = 1'b0;
      if (p_arv && p_arr) begin
        pend = 1;
        dly  = $urandom_range(0, 2);
        tmp  = $urandom();
        if (p_addr == ST_A) begin
          pdata = tmp;
          pdata[1] = 1'b0;
          pdata[2] = 1'b0;
          if (status_q.size() > 0) pdata = status_q.pop_front();
        end else begin
          pdata = {tmp[31:8], 8'h00};
          if (rx_q.size() > 0) pdata[7:0] = rx_q.pop_front();
        end
      end
      if (pend && !m_rvalid_i) begin
        if (dly == 0) begin
          m_rvalid_i = 1'b1;
          m_rdata_i  = pdata;
          pend       = 0;
        end else dly--;
      end
      m_arready_i = ($urandom_range(0, 2) != 0);
      if (mem_wr_o && stall > 0) begin
        mem_accept_i = 1'b0;
        stall--;
      end else mem_accept_i = 1'($urandom_range(0, 1));
    end
    p_arv  = m_arvalid_o;
    p_arr  = m_arready_i;
    p_rv   = m_rvalid_i;
    p_rr   = m_rready_o;
    p_addr = m_araddr_o[7:0];
  end

  // Monitor: samples on the falling edge, handshakes seen here complete on the next rising edge.
  bit          ar_seen = 0, ar_wait = 0, cur_rx = 0, last_rx = 0, pm_wait = 0;
  int          r_cyc = 0;
  logic [31:0] p_araddr = '0, pm_addr = '0, pm_data = '0;
  logic [3:0]  pm_strb = '0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      ar_seen = 0; ar_wait = 0; pm_wait = 0; last_rx = 0;
    end else begin
      if (ar_wait && (!m_arvalid_o || m_araddr_o !== p_araddr)) proto_err++;
      if (m_arvalid_o && !ar_seen) begin
        ar_seen = 1;
        if (m_araddr_o[7:0] == RX_A && last_rx) begin
          total++;
          if (cyc - r_cyc < RD_GAP) begin
            bad++;
            $display("FAIL rd_gap: got %0d idle cycles expected >= %0d", cyc - r_cyc, RD_GAP);
          end
        end
      end
      ar_wait  = m_arvalid_o && !m_arready_i;
      p_araddr = m_araddr_o;
      if (m_arvalid_o && m_arready_i) begin
        ar_seen = 0;
        cur_rx  = (m_araddr_o[7:0] == RX_A);
        if (m_araddr_o[7:0] == ST_A) st_reads++;
      end
      if (m_rvalid_i && m_rready_o) begin
        last_rx = cur_rx;
        if (cur_rx) begin
          r_cyc = cyc + 1;
          rx_reads++;
        end
      end
      if (mem_wr_o) begin
        if (m_arvalid_o || m_rready_o) proto_err++;
        if (pm_wait && {mem_addr_o, mem_wdata_o, mem_wstrb_o} !== {pm_addr, pm_data, pm_strb})
          proto_err++;
        if (mem_accept_i) begin
          if (exp_wr.size() == 0) begin
            total++; bad++;
            $display("FAIL mem_unexpected: got addr %h expected no write", mem_addr_o);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            check32("mem_addr", mem_addr_o, e.addr);
            check32("mem_strb", {28'd0, mem_wstrb_o}, {28'd0, e.strb});
            check32("mem_data", mem_wdata_o & lane_mask(e.strb), e.data & lane_mask(e.strb));
          end
        end
        pm_wait = !mem_accept_i;
        pm_addr = mem_addr_o; pm_data = mem_wdata_o; pm_strb = mem_wstrb_o;
      end else begin
        if (pm_wait) proto_err++;
        pm_wait = 0;
      end
      if (done_o) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got done_o=1 expected 0");
        end else begin
          done_t d;
          d = exp_done.pop_front();
          check32("done_err", {31'd0, err_o}, {31'd0, d.err});
          check32("done_len", {16'd0, rx_len_o}, {16'd0, d.len});
          check32("done_busy", {31'd0, busy_o}, 32'd0);
          check32("writes_left", exp_wr.size(), 0);
        end
      end
    end
  end

  task automatic run_frame(input int n_empty, input bit rxreset, input int len, input int maxl,
                           input logic [31:0] base, input int stall_cyc, input bit fixed);
    logic [7:0]  pl[$];
    logic [31:0] s, ab, d;
    logic [3:0]  sb;
    int st0, rx0, d0, pe0;
    done_t dn;
    wr_t w;
    for (int i = 0; i < n_empty; i++) begin
      s = $urandom(); s[1] = 1'b1; s[2] = 1'b0; status_q.push_back(s);
    end
    s = $urandom(); s[1] = 1'b0; s[2] = rxreset; status_q.push_back(s);
    if (!rxreset) begin
      s = len;
      rx_q.push_back(s[15:8]);
      rx_q.push_back(s[7:0]);
      for (int i = 0; i < len; i++) begin
        s = fixed ? 32'(8'h11 * (i + 1)) : $urandom();
        pl.push_back(s[7:0]);
        rx_q.push_back(s[7:0]);
      end
    end
    // Reference: bytes grouped four at a time, little-endian, from the aligned base.
    ab = {base[31:2], 2'b00};
    if (rxreset) begin dn.err = 1'b1; dn.len = 16'd0; end
    else if (len == 0) begin dn.err = 1'b0; dn.len = 16'd0; end
    else if (len > maxl) begin dn.err = 1'b1; dn.len = 16'(len); end
    else begin
      for (int k = 0; k * 4 < len; k++) begin
        d = 32'd0; sb = 4'd0;
        for (int b = 0; b < 4 && k * 4 + b < len; b++) begin
          d = d | (32'(pl[k * 4 + b]) << (8 * b));
          sb[b] = 1'b1;
        end
        w.addr = ab + 32'(4 * k); w.data = d; w.strb = sb;
        exp_wr.push_back(w);
      end
      dn.err = 1'b0; dn.len = 16'(len);
    end
    exp_done.push_back(dn);
    st0 = st_reads; rx0 = rx_reads; d0 = done_cnt; pe0 = proto_err;
    @(posedge clk); #2;
    base_addr_i = base; max_len_i = 16'(maxl); start_i = 1'b1; stall = stall_cyc;
    @(posedge clk); #2;
    start_i = 1'b0; base_addr_i = $urandom(); max_len_i = 16'($urandom());
    repeat (2) @(posedge clk);
    #2 start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    @(negedge clk);
    check32("done_seen", done_cnt - d0, 1);
    check32("status_reads", st_reads - st0, n_empty + 1);
    check32("rx_reads", rx_reads - rx0, rxreset ? 0 : 2 + len);
    check32("proto_err", proto_err - pe0, 0);
    check32("slave_queues_left", status_q.size() + rx_q.size(), 0);
    status_q.delete(); rx_q.delete(); exp_wr.delete(); exp_done.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_ctrl", {23'd0, busy_o, done_o, err_o, m_arvalid_o, m_rready_o, mem_wr_o,
                         m_awvalid_o, m_wvalid_o, m_bready_o}, 32'h1);
    check32("rst_len", {16'd0, rx_len_o}, 32'd0);
    check32("rst_mem", mem_addr_o | mem_wdata_o | {28'd0, mem_wstrb_o}, 32'd0);
    @(negedge clk) rst_ni = 1'b1;

    run_frame(3, 0, 5, 64, 32'h1000_0003, 0, 1);
    run_frame(0, 0, 0, 64, 32'h2000_0000, 0, 0);
    run_frame(1, 0, 6, 4, 32'h3000_0000, 0, 0);
    run_frame(0, 0, 9, 64, 32'h4000_0010, 10, 0);
    run_frame(2, 1, 0, 64, 32'h5000_0000, 0, 0);
    run_frame(0, 0, 8, 8, 32'h6000_0000, 1, 0);
    run_frame(0, 0, 9, 8, 32'h6000_0100, 0, 0);
    run_frame(1, 0, 12, 16, 32'hFFFF_FFF8, 2, 0);
    for (int n = 0; n < 12; n++)
      run_frame($urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom_range(0, 20),
                $urandom_range(0, 24), $urandom(), $urandom_range(0, 3), 0);

    // Reset mid-DATA must abort silently; the next start begins again at the STATUS poll.
    for (int i = 0; i < 40; i++) rx_q.push_back(8'(i));
    rx_q.push_front(8'd38);
    rx_q.push_front(8'd0);
    status_q.push_back(32'h0);
    rx0 = rx_reads;
    @(posedge clk); #2;
    base_addr_i = 32'h7000_0000; max_len_i = 16'd100; start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
    for (int i = 0; i < 3000 && rx_reads - rx0 < 6; i++) @(posedge clk);
    check32("pre_reset_reads", (rx_reads - rx0 >= 6) ? 1 : 0, 1);
    @(negedge clk); #2 rst_ni = 1'b0;
    #1;
    check32("abort_ctrl", {23'd0, busy_o, done_o, err_o, m_arvalid_o, m_rready_o, mem_wr_o,
                           m_awvalid_o, m_wvalid_o, m_bready_o}, 32'h1);
    check32("abort_len", {16'd0, rx_len_o}, 32'd0);
    check32("abort_mem", mem_addr_o | mem_wdata_o | {28'd0, mem_wstrb_o}, 32'd0);
    status_q.delete(); rx_q.delete(); exp_wr.delete(); exp_done.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_ni = 1'b1;
    run_frame(1, 0, 7, 64, 32'h7000_0000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
